// File: rtl/hazard_scoreboard_if.sv
// rtl/hazard_scoreboard_if.sv - ID-stage request/response bundle between decode and the hazard scoreboard
interface hazard_scoreboard_if #(
    parameter int NUM_REGS = 16,
    parameter int REG_AW   = 4
);
    logic              id_valid;
    logic [REG_AW-1:0] id_rs1;
    logic              id_rs1_used;
    logic [REG_AW-1:0] id_rs2;
    logic              id_rs2_used;
    logic [REG_AW-1:0] id_rd;
    logic              id_rd_we;
    logic              id_is_load;
    logic              id_is_mul;
    logic              branch_taken;
    logic              stall;
    logic              flush;
    logic              issue;
    logic [NUM_REGS-1:0] busy_mask;

    modport master (
        output id_valid, id_rs1, id_rs1_used, id_rs2, id_rs2_used,
               id_rd, id_rd_we, id_is_load, id_is_mul, branch_taken,
        input  stall, flush, issue, busy_mask
    );

    modport slave (
        input  id_valid, id_rs1, id_rs1_used, id_rs2, id_rs2_used,
               id_rd, id_rd_we, id_is_load, id_is_mul, branch_taken,
        output stall, flush, issue, busy_mask
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - per-register result scoreboard with RAW/WAW stall and multi-cycle branch flush
// Optional stall/flush performance counters enabled by macro HAZARD_PERF_EN.
module hazard_scoreboard #(
    parameter int NUM_REGS     = 16,
    parameter int REG_AW       = 4,
    parameter int LOAD_LAT     = 1,
    parameter int MUL_LAT      = 3,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    hazard_scoreboard_if.slave   hz
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]          stall_cycles,
    output logic [31:0]          flush_cycles
`endif
);

    if (LOAD_LAT < 1 || LOAD_LAT > 15) begin : g_bad_load_lat
        $error("LOAD_LAT must be within 1..15");
    end
    if (MUL_LAT < 1 || MUL_LAT > 15) begin : g_bad_mul_lat
        $error("MUL_LAT must be within 1..15");
    end
    if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 15) begin : g_bad_flush_cycles
        $error("FLUSH_CYCLES must be within 1..15");
    end
    if (NUM_REGS < 1 || NUM_REGS > (1 << REG_AW)) begin : g_bad_num_regs
        $error("NUM_REGS must be within 1..2**REG_AW");
    end

    logic [3:0] cnt [NUM_REGS];
    logic [3:0] fcnt;
    logic [3:0] rs1_cnt;
    logic [3:0] rs2_cnt;
    logic [3:0] rd_cnt;
    logic [3:0] lat;
    logic       raw_hazard;
    logic       waw_hazard;

    // Out-of-range indices match no entry, so they read as never busy and are never recorded.
    always_comb begin
        rs1_cnt = '0;
        rs2_cnt = '0;
        rd_cnt  = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (hz.id_rs1 == REG_AW'(i)) rs1_cnt = cnt[i];
            if (hz.id_rs2 == REG_AW'(i)) rs2_cnt = cnt[i];
            if (hz.id_rd  == REG_AW'(i)) rd_cnt  = cnt[i];
        end
    end

    always_comb begin
        lat = 4'd0;
        if (hz.id_is_load)     lat = 4'(LOAD_LAT);
        else if (hz.id_is_mul) lat = 4'(MUL_LAT);
    end

    assign raw_hazard = (hz.id_rs1_used && rs1_cnt != 4'd0) ||
                        (hz.id_rs2_used && rs2_cnt != 4'd0);
    // A shorter-latency writer may issue once the older result lands no later than its own.
    assign waw_hazard = hz.id_rd_we && (rd_cnt > lat);

    assign hz.flush = hz.branch_taken || (fcnt != 4'd0);
    assign hz.stall = hz.id_valid && !hz.flush && (raw_hazard || waw_hazard);
    assign hz.issue = hz.id_valid && !hz.stall && !hz.flush;

    always_comb begin
        hz.busy_mask = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            hz.busy_mask[i] = (cnt[i] != 4'd0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                cnt[i] <= 4'd0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (hz.issue && hz.id_rd_we && lat != 4'd0 && hz.id_rd == REG_AW'(i)) begin
                    cnt[i] <= lat;
                end else if (cnt[i] != 4'd0) begin
                    cnt[i] <= cnt[i] - 4'd1;
                end
            end
        end
    end

    // A new taken branch restarts the window rather than extending it additively.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fcnt <= 4'd0;
        end else if (hz.branch_taken) begin
            fcnt <= 4'(FLUSH_CYCLES - 1);
        end else if (fcnt != 4'd0) begin
            fcnt <= fcnt - 4'd1;
        end
    end

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
            flush_cycles <= '0;
        end else begin
            if (hz.stall && stall_cycles != '1) stall_cycles <= stall_cycles + 32'd1;
            if (hz.flush && flush_cycles != '1) flush_cycles <= flush_cycles + 32'd1;
        end
    end
`endif

endmodule
